// File: rtl/gap_accum_pool.sv
// Global-average-pooling engine: accumulates a pixel-major stream per channel group, then drains averages.
// Optional GAP_ROUND_EN: round-half-up before the reciprocal shift (default: truncate).
module gap_accum_pool #(
    parameter int LANES      = 4,
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 24,
    parameter int MAX_GROUPS = 288,
    parameter int RECIP_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cfg_start,
    input  logic [15:0]               cfg_groups,
    input  logic [15:0]               cfg_pixels,
    input  logic [RECIP_W-1:0]        cfg_recip,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic                      busy,
    output logic                      done
);
    localparam int AW = (MAX_GROUPS > 1) ? $clog2(MAX_GROUPS) : 1;
    localparam int PW = ACC_W + RECIP_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W+1-DATA_W){1'b0}}, b};
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] scale_sat(input logic [ACC_W-1:0] a, input logic [RECIP_W-1:0] r);
        logic [PW-1:0] prod;
        logic [PW-1:0] q;
        prod = PW'(a) * PW'(r);
`ifdef GAP_ROUND_EN
        prod = prod + (PW'(1) << (RECIP_W-1));
`endif
        q = prod >> RECIP_W;
        return (|q[PW-1:DATA_W]) ? '1 : q[DATA_W-1:0];
    endfunction

    state_t                   state;
    logic [15:0]              groups_q, pixels_q;
    logic [RECIP_W-1:0]       recip_q;
    logic [15:0]              g_cnt, p_cnt, dg;
    logic                     rd_req_q, cmp_q;
    logic                     vld_p1, last_p1, first_p1, fwd_p1;
    logic [AW-1:0]            g_p1;
    logic [LANES*DATA_W-1:0]  lane_p1;
    logic [LANES*ACC_W-1:0]   fwd_data_p1, base_p1, wr_data, rd_data;
    logic [LANES*DATA_W-1:0]  avg_data;
    logic [LANES*ACC_W-1:0]   mem [0:MAX_GROUPS-1];

    logic          accept, last_beat, drain_rd, rd_en;
    logic [AW-1:0] rd_addr;

    assign accept    = (state == S_ACCUM) && in_ready && in_valid;
    assign last_beat = (g_cnt == groups_q - 16'd1) && (p_cnt == pixels_q - 16'd1);
    assign drain_rd  = (state == S_DRAIN) && (rd_req_q || (out_valid && out_ready && dg != groups_q));
    assign rd_en     = accept || drain_rd;
    assign rd_addr   = accept ? g_cnt[AW-1:0] : dg[AW-1:0];
    // First pixel seeds the RAM; a write still in flight to the same group is forwarded.
    assign base_p1   = first_p1 ? '0 : (fwd_p1 ? fwd_data_p1 : rd_data);

    always_comb begin
        wr_data  = '0;
        avg_data = '0;
        for (int i = 0; i < LANES; i++) begin
            wr_data[i*ACC_W +: ACC_W]   = sat_add(base_p1[i*ACC_W +: ACC_W], lane_p1[i*DATA_W +: DATA_W]);
            avg_data[i*DATA_W +: DATA_W] = scale_sat(rd_data[i*ACC_W +: ACC_W], recip_q);
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1) mem[g_p1] <= wr_data;
        if (rd_en)  rd_data   <= mem[rd_addr];
    end

    // Stage p1: beat accepted, RAM read in flight
    always_ff @(posedge clk) begin
        if (accept) begin
            g_p1        <= g_cnt[AW-1:0];
            first_p1    <= (p_cnt == 16'd0);
            lane_p1     <= in_data;
            fwd_p1      <= vld_p1 && (g_p1 == g_cnt[AW-1:0]);
            fwd_data_p1 <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            groups_q  <= '0;
            pixels_q  <= '0;
            recip_q   <= '0;
            g_cnt     <= '0;
            p_cnt     <= '0;
            dg        <= '0;
            rd_req_q  <= 1'b0;
            cmp_q     <= 1'b0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_req_q <= 1'b0;
            cmp_q    <= drain_rd;
            vld_p1   <= accept;
            last_p1  <= accept && last_beat;
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        groups_q <= cfg_groups;
                        pixels_q <= cfg_pixels;
                        recip_q  <= cfg_recip;
                        g_cnt    <= '0;
                        p_cnt    <= '0;
                        busy     <= 1'b1;
                        if (cfg_groups == 16'd0 || cfg_pixels == 16'd0 || cfg_groups > 16'(MAX_GROUPS)) begin
                            state <= S_DONE;
                        end else begin
                            state    <= S_ACCUM;
                            in_ready <= 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        if (last_beat) begin
                            in_ready <= 1'b0;
                        end else if (g_cnt == groups_q - 16'd1) begin
                            g_cnt <= '0;
                            p_cnt <= p_cnt + 16'd1;
                        end else begin
                            g_cnt <= g_cnt + 16'd1;
                        end
                    end
                    if (vld_p1 && last_p1) begin
                        state    <= S_DRAIN;
                        dg       <= '0;
                        rd_req_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (cmp_q) begin
                        out_data  <= avg_data;
                        out_valid <= 1'b1;
                        dg        <= dg + 16'd1;
                    end
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (dg == groups_q) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
